deb_logic_combiner: RTL

Parametrised successor to the small registered 3-input logic cell. Takes N_IN asynchronous single-bit inputs and passes each through a 2-flop synchroniser and a per-channel debounce filter. It reduces the filtered vector with a run-time selectable function (AND/OR/XOR/majority) into a registered output, with valid and change flags. It sits between raw board inputs (buttons/switches) and downstream control logic.

---
 rtl/deb_logic_combiner.sv | 116 +++++++++++
 1 files changed

// File: rtl/deb_logic_combiner.sv
// Debounced N-input logic combiner: 2-flop synchroniser and per-channel debounce
// filter feeding a run-time selectable AND/OR/XOR/majority reduction register.
module deb_logic_combiner #(
  parameter int N_IN       = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [N_IN-1:0] din,
  output logic            d,
  output logic            d_valid,
  output logic            change
);
  localparam int CNT_W  = $clog2(DEB_CYCLES) + 1;
  // Warm-up target DEB_CYCLES+2 can exceed CNT_W for small DEB_CYCLES, so it gets its own width.
  localparam int WARM_W = $clog2(DEB_CYCLES + 3);
  localparam int POP_W  = $clog2(N_IN + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WARM_W-1:0] WARM_SAT = WARM_W'(DEB_CYCLES + 2);
  localparam logic [POP_W-1:0]  MAJ_THR  = POP_W'(N_IN / 2);

  logic [N_IN-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic [N_IN-1:0]   filt_q, filt_d;
  logic [CNT_W-1:0]  cnt_q [N_IN];
  logic [CNT_W-1:0]  cnt_d [N_IN];
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [POP_W-1:0]  pop_s;
  logic              red_s;
  logic              d_q, d_d;
  logic              dv_q, dv_d;
  logic              chg_q, chg_d;

  // Synchroniser and per-channel debounce next-state.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    filt_d = filt_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == filt_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = s2_q[i];
        cnt_d[i]  = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Reduction of the filtered vector under the current mode.
  always_comb begin
    pop_s = {POP_W{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      pop_s = pop_s + POP_W'(filt_q[i]);
    end
    case (mode)
      2'b00:   red_s = &filt_q;
      2'b01:   red_s = |filt_q;
      2'b10:   red_s = ^filt_q;
      2'b11:   red_s = (pop_s > MAJ_THR);
      default: red_s = 1'b0;
    endcase
  end

  // Output stage and warm-up tracking; en low freezes d and restarts warm-up.
  always_comb begin
    if (en) begin
      warm_d = (warm_q == WARM_SAT) ? warm_q : (warm_q + WARM_W'(1));
      d_d    = red_s;
      chg_d  = (red_s != d_q);
      dv_d   = (warm_d == WARM_SAT);
    end else begin
      warm_d = {WARM_W{1'b0}};
      d_d    = d_q;
      chg_d  = 1'b0;
      dv_d   = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= {N_IN{1'b0}};
      s2_q   <= {N_IN{1'b0}};
      filt_q <= {N_IN{1'b0}};
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      warm_q <= {WARM_W{1'b0}};
      d_q    <= 1'b0;
      dv_q   <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      warm_q <= warm_d;
      d_q    <= d_d;
      dv_q   <= dv_d;
      chg_q  <= chg_d;
    end
  end

  assign d       = d_q;
  assign d_valid = dv_q;
  assign change  = chg_q;

endmodule
